cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 29 ++
 rtl/rr_picker.sv | 46 ++++
 rtl/cdb_arbiter.sv | 143 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cdb_pkg                                                     |
// | Description : Shared constants for the common-data-bus arbiter: FSM      |
// |               state encoding, default bus widths, performance-counter    |
// |               width and an index-width helper.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cdb_pkg;

  // FSM state encoding
  localparam logic [0:0] c_ST_RUN   = 1'b0;
  localparam logic [0:0] c_ST_FLUSH = 1'b1;

  // Default bus widths
  localparam int c_DEF_TAG_W  = 4;
  localparam int c_DEF_DATA_W = 32;

  // Performance counter width and saturation value
  localparam int                 c_CNT_W   = 16;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

  // Width of an index into n requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_picker                                                   |
// | Description : Combinational round-robin picker. Scans req starting at    |
// |               index start, wrapping past N_REQ-1 to 0, and returns the   |
// |               first requester found as a one-hot grant plus its index.   |
// | Ports       : req   - request vector                                     |
// |               start - first index to examine (must be < N_REQ)           |
// |               grant - one-hot winner, zero when req is zero              |
// |               idx   - index of the winner (0 when no winner)             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_picker import cdb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_REQ - 1);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Walk the candidate index modulo N_REQ so non-power-of-two counts wrap
  // correctly; the first requester met wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = start;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        grant[w_cand] = 1'b1;
        idx           = w_cand;
      end
      w_cand = (w_cand == c_LAST) ? '0 : w_cand + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cdb_arbiter                                                 |
// | Description : Round-robin arbiter for the common data bus. Grants one    |
// |               result requester per cycle (combinationally) and           |
// |               broadcasts its tag/data one cycle later. A ROB flush       |
// |               suppresses grants while high plus one drain cycle.         |
// | Ports       : clock, resetN (async active-low)                           |
// |               req/reqTag/reqData - per-unit result requests              |
// |               flush              - branch-mispredict flush               |
// |               grant              - one-hot grant, same cycle as req      |
// |               cdbValid/Tag/Data  - registered broadcast                  |
// |               cdbIdle            - no request and no broadcast           |
// |               grantCount/conflictCount - only with CDB_PERF_CNT_EN       |
// | Config      : define CDB_PERF_CNT_EN to add saturating perf counters.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cdb_arbiter import cdb_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = c_DEF_TAG_W,
  parameter int DATA_W = c_DEF_DATA_W
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*TAG_W-1:0]  reqTag,
  input  logic [N_REQ*DATA_W-1:0] reqData,
  input  logic                flush,
  output logic [N_REQ-1:0]    grant,
  output logic                cdbValid,
  output logic [TAG_W-1:0]    cdbTag,
  output logic [DATA_W-1:0]   cdbData,
  output logic                cdbIdle
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [N_REQ*c_CNT_W-1:0] grantCount,
  output logic [c_CNT_W-1:0]       conflictCount
`endif
);

  localparam int               IDX_W  = idx_width(N_REQ);
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_REQ - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [IDX_W-1:0]  r_last_ptr;
  logic [IDX_W-1:0]  w_start;
  logic [N_REQ-1:0]  w_pick_grant;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [N_REQ-1:0]  w_grant;
  logic              w_any_grant;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [DATA_W-1:0] w_sel_data;

  // Search begins one past the last winner, wrapping to 0.
  assign w_start = (r_last_ptr == c_LAST) ? '0 : r_last_ptr + 1'b1;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req),
    .start (w_start),
    .grant (w_pick_grant),
    .idx   (w_pick_idx)
  );

  // Flush masks the grant immediately; the FLUSH state covers the drain.
  assign w_grant     = (r_state == c_ST_RUN && !flush) ? w_pick_grant : '0;
  assign w_any_grant = |w_grant;
  assign grant       = w_grant;

  // One-hot mux of the winner's tag and data.
  always_comb begin
    w_sel_tag  = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_tag  = reqTag[i*TAG_W +: TAG_W];
        w_sel_data = reqData[i*DATA_W +: DATA_W];
      end
    end
  end

  // The FLUSH cycle in which flush is already low is the drain cycle, so
  // leaving FLUSH only depends on flush being low.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:   w_state_nxt = flush ? c_ST_FLUSH : c_ST_RUN;
      c_ST_FLUSH: w_state_nxt = flush ? c_ST_FLUSH : c_ST_RUN;
      default:    w_state_nxt = c_ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= c_ST_RUN;
      r_last_ptr <= c_LAST;
      cdbValid   <= 1'b0;
      cdbTag     <= '0;
      cdbData    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      cdbValid <= w_any_grant;
      if (w_any_grant) begin
        r_last_ptr <= w_pick_idx;
        cdbTag     <= w_sel_tag;
        cdbData    <= w_sel_data;
      end
    end
  end

  assign cdbIdle = ~|req & ~cdbValid;

`ifdef CDB_PERF_CNT_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_cnt
    logic [c_CNT_W-1:0] r_cnt;
    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        r_cnt <= '0;
      end else if (w_grant[gi] && r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign grantCount[gi*c_CNT_W +: c_CNT_W] = r_cnt;
  end

  logic r_unused_dummy;
  logic [c_CNT_W-1:0] r_conflict_cnt;
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_conflict_cnt <= '0;
    end else if (w_any_grant && ($countones(req) > 1) && r_conflict_cnt != c_CNT_MAX) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end
  assign conflictCount  = r_conflict_cnt;
  assign r_unused_dummy = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cdb_arbiter                                              |
// | Description : Directed self-checking bench for cdb_arbiter: reset,       |
// |               round-robin order, single request, wrap-around, flush,     |
// |               reset mid-broadcast and (with CDB_PERF_CNT_EN) counters.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cdb_arbiter;

  logic         clock;
  logic         resetN;
  logic [3:0]   req;
  logic [15:0]  reqTag;
  logic [127:0] reqData;
  logic         flush;
  logic [3:0]   grant;
  logic         cdbValid;
  logic [3:0]   cdbTag;
  logic [31:0]  cdbData;
  logic         cdbIdle;
`ifdef CDB_PERF_CNT_EN
  logic [63:0]  grantCount;
  logic [15:0]  conflictCount;
`endif

  int vecs = 0;
  int errs = 0;

  cdb_arbiter #(.N_REQ(4), .TAG_W(4), .DATA_W(32)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .req      (req),
    .reqTag   (reqTag),
    .reqData  (reqData),
    .flush    (flush),
    .grant    (grant),
    .cdbValid (cdbValid),
    .cdbTag   (cdbTag),
    .cdbData  (cdbData),
    .cdbIdle  (cdbIdle)
`ifdef CDB_PERF_CNT_EN
    ,
    .grantCount    (grantCount),
    .conflictCount (conflictCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    resetN  = 1'b0;
    req     = 4'b0000;
    flush   = 1'b0;
    reqTag  = {4'hB, 4'hA, 4'h9, 4'h8};
    reqData = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    tick;
    tick;
    vecs++; if (cdbValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cdbValid);
    if (cdbValid !== 1'b0) errs++;
    vecs++; if (cdbTag !== 4'h0 || cdbData !== 32'h0) begin
      errs++; $display("FAIL reset_tagdata: got %h/%h want 0/0", cdbTag, cdbData);
    end
    vecs++; if (grant !== 4'b0000 || cdbIdle !== 1'b1) begin
      errs++; $display("FAIL reset_grant_idle: got %b/%b want 0000/1", grant, cdbIdle);
    end
    resetN = 1'b1;
    tick;
  endtask

  // Fresh reset, all four request: grants go 0,1,2,3 with tags one cycle later.
  task automatic test_round_robin;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      vecs++; if (grant !== 4'(1 << k)) begin
        errs++; $display("FAIL rr_grant%0d: got %b want %b", k, grant, 4'(1 << k));
      end
      tick;
      vecs++; if (cdbValid !== 1'b1 || cdbTag !== 4'(8 + k)) begin
        errs++; $display("FAIL rr_bcast%0d: got v=%b tag=%h want v=1 tag=%h", k, cdbValid, cdbTag, 4'(8 + k));
      end
    end
    req = 4'b0000;
  endtask

  // Last winner was unit 3, so 1001 goes to unit 0, then 3, then 0.
  task automatic test_wrap;
    req = 4'b1001;
    #1;
    vecs++; if (grant !== 4'b0001) begin
      errs++; $display("FAIL wrap_first: got %b want 0001", grant);
    end
    tick;
    #1;
    vecs++; if (grant !== 4'b1000) begin
      errs++; $display("FAIL wrap_second: got %b want 1000", grant);
    end
    tick;
    #1;
    vecs++; if (grant !== 4'b0001) begin
      errs++; $display("FAIL wrap_third: got %b want 0001", grant);
    end
    tick;
    req = 4'b0000;
    vecs++; if (cdbValid !== 1'b1 || cdbTag !== 4'h8 || cdbData !== 32'hA000_0000) begin
      errs++; $display("FAIL wrap_bcast: got v=%b %h/%h want 1 8/a0000000", cdbValid, cdbTag, cdbData);
    end
    tick;
    vecs++; if (cdbValid !== 1'b0 || cdbTag !== 4'h8 || cdbIdle !== 1'b1) begin
      errs++; $display("FAIL idle_hold: got v=%b tag=%h idle=%b want 0 8 1", cdbValid, cdbTag, cdbIdle);
    end
  endtask

  task automatic test_single;
    reqTag[11:8]   = 4'h7;
    reqData[95:64] = 32'hDEAD_BEEF;
    req = 4'b0100;
    #1;
    vecs++; if (grant !== 4'b0100 || cdbIdle !== 1'b0) begin
      errs++; $display("FAIL single_grant: got %b idle=%b want 0100 0", grant, cdbIdle);
    end
    tick;
    req = 4'b0000;
    vecs++; if (cdbValid !== 1'b1 || cdbTag !== 4'h7 || cdbData !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL single_bcast: got v=%b %h/%h want 1 7/deadbeef", cdbValid, cdbTag, cdbData);
    end
  endtask

  // Last winner is unit 2; a one-cycle flush masks two cycles, then 0011 -> unit 0.
  task automatic test_flush_pulse;
    req   = 4'b0011;
    flush = 1'b1;
    #1;
    vecs++; if (grant !== 4'b0000) begin
      errs++; $display("FAIL flush_grant: got %b want 0000", grant);
    end
    tick;
    flush = 1'b0;
    #1;
    vecs++; if (grant !== 4'b0000 || cdbValid !== 1'b0) begin
      errs++; $display("FAIL drain_grant: got %b v=%b want 0000 0", grant, cdbValid);
    end
    tick;
    #1;
    vecs++; if (grant !== 4'b0001 || cdbValid !== 1'b0) begin
      errs++; $display("FAIL flush_resume: got %b v=%b want 0001 0", grant, cdbValid);
    end
    tick;
    #1;
    vecs++; if (grant !== 4'b0010 || cdbValid !== 1'b1 || cdbTag !== 4'h8) begin
      errs++; $display("FAIL flush_next: got %b v=%b tag=%h want 0010 1 8", grant, cdbValid, cdbTag);
    end
    tick;
    req = 4'b0000;
    tick;
  endtask

  task automatic test_reset_mid;
    req = 4'b0100;
    #1;
    vecs++; if (grant !== 4'b0100) begin
      errs++; $display("FAIL mid_grant: got %b want 0100", grant);
    end
    tick;
    vecs++; if (cdbValid !== 1'b1) begin
      errs++; $display("FAIL mid_valid: got %b want 1", cdbValid);
    end
    resetN = 1'b0;
    req    = 4'b0000;
    #1;
    vecs++; if (cdbValid !== 1'b0 || cdbIdle !== 1'b1 || cdbTag !== 4'h0) begin
      errs++; $display("FAIL mid_reset: got v=%b idle=%b tag=%h want 0 1 0", cdbValid, cdbIdle, cdbTag);
    end
    tick;
    resetN = 1'b1;
    tick;
    req = 4'b1111;
    #1;
    vecs++; if (grant !== 4'b0001) begin
      errs++; $display("FAIL post_reset_grant: got %b want 0001", grant);
    end
    tick;
    req = 4'b0000;
    tick;
  endtask

  // Last winner unit 0; flush held two cycles plus drain, then 0110 -> unit 1.
  task automatic test_flush_hold;
    req   = 4'b0110;
    flush = 1'b1;
    #1;
    vecs++; if (grant !== 4'b0000) begin
      errs++; $display("FAIL hold_grant0: got %b want 0000", grant);
    end
    tick;
    #1;
    vecs++; if (grant !== 4'b0000 || cdbValid !== 1'b0) begin
      errs++; $display("FAIL hold_grant1: got %b v=%b want 0000 0", grant, cdbValid);
    end
    tick;
    flush = 1'b0;
    #1;
    vecs++; if (grant !== 4'b0000) begin
      errs++; $display("FAIL hold_drain: got %b want 0000", grant);
    end
    tick;
    #1;
    vecs++; if (grant !== 4'b0010) begin
      errs++; $display("FAIL hold_resume: got %b want 0010", grant);
    end
    tick;
    req = 4'b0000;
    tick;
  endtask

`ifdef CDB_PERF_CNT_EN
  task automatic test_perf_counters;
    logic [15:0] g0;
    resetN = 1'b0;
    tick;
    resetN = 1'b1;
    tick;
    req = 4'b0001;
    for (int c = 0; c < 70000; c++) tick;
    req = 4'b0000;
    g0 = grantCount[15:0];
    vecs++; if (g0 !== 16'hFFFF) begin
      errs++; $display("FAIL perf_grant0: got %h want ffff", g0);
    end
    vecs++; if (conflictCount !== 16'h0000) begin
      errs++; $display("FAIL perf_conflict: got %h want 0000", conflictCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_single();
    test_flush_pulse();
    test_reset_mid();
    test_flush_hold();
`ifdef CDB_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
